// File: rtl/wb_vpic_pkg.sv
// Shared constants and helpers for the vectored Wishbone interrupt controller.
package wb_vpic_pkg;
   localparam logic [2:0] ADDR_MASK  = 3'd0;
   localparam logic [2:0] ADDR_EDGE  = 3'd1;
   localparam logic [2:0] ADDR_PEND  = 3'd2;
   localparam logic [2:0] ADDR_INSVC = 3'd3;
   localparam logic [2:0] ADDR_VEC   = 3'd4;
   localparam logic [2:0] ADDR_EOI   = 3'd5;
   localparam logic [2:0] ADDR_FORCE = 3'd6;

   function automatic int calc_iw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // VEC valid flag sits in the top bit of the data bus.
   function automatic int vec_vld_pos(input int dw);
      return dw - 1;
   endfunction
endpackage

// File: rtl/wb_vpic_if.sv
// Wishbone slave bus bundle for wb_vpic.
interface wb_vpic_if #(
   parameter int DW = 32
);
   logic            wb_cyc;
   logic            wb_stb;
   logic            wb_we;
   logic [DW/8-1:0] wb_sel;
   logic [2:0]      wb_adr;
   logic [DW-1:0]   wb_dat_i;
   logic [DW-1:0]   wb_dat_o;
   logic            wb_ack;

   modport master (output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
                   input  wb_dat_o, wb_ack);
   modport slave  (input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
                   output wb_dat_o, wb_ack);
endinterface

// File: rtl/vpic_pri_enc.sv
// Lowest-set-index priority encoder; index reads 0 when nothing is set.
module vpic_pri_enc
   import wb_vpic_pkg::*;
#(
   parameter int  N = 8,
   localparam int W = calc_iw(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         vld_o
);
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = W'(i);
            vld_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_vpic.sv
// Vectored Wishbone interrupt controller with nested priority.
// Requests pass a 2-flop synchroniser; pending and in-service state are bus visible.
module wb_vpic
   import wb_vpic_pkg::*;
#(
   parameter int  NIRQ = 8,
   parameter int  DW   = 32,
   localparam int IW   = calc_iw(NIRQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq_i,
   wb_vpic_if.slave        wb,
   output logic            wb_irq,
   output logic [IW-1:0]   irq_no
);
   localparam int VB = vec_vld_pos(DW);

   logic [NIRQ-1:0] sy1_q, sy2_q, prv_q, rise;
   logic [NIRQ-1:0] mask_q, mask_d, edge_q, edge_d, pend_q, pend_d, insvc_q, insvc_d;
   logic [NIRQ-1:0] bsel, wn, p_hot, eoi_hot;
   logic [DW-1:0]   dat_q, dat_d, rdata;
   logic            ack_q, ack_d, wr, rd, p_vld, s_vld;
   logic [IW-1:0]   p_idx, s_idx;

   vpic_pri_enc #(.N(NIRQ)) u_pend_enc (.req_i(pend_q & mask_q), .idx_o(p_idx), .vld_o(p_vld));
   vpic_pri_enc #(.N(NIRQ)) u_svc_enc  (.req_i(insvc_q),         .idx_o(s_idx), .vld_o(s_vld));

   assign wb_irq      = p_vld & (~s_vld | (p_idx < s_idx));
   assign irq_no      = p_idx;
   assign rise        = sy2_q & ~prv_q;
   assign p_hot       = NIRQ'(1) << p_idx;
   assign eoi_hot     = NIRQ'(1) << wb.wb_dat_i[IW-1:0];
   assign ack_d       = wb.wb_cyc & wb.wb_stb & ~ack_q;
   assign wr          = ack_d & wb.wb_we;
   assign rd          = ack_d & ~wb.wb_we;
   assign wn          = wb.wb_dat_i[NIRQ-1:0] & bsel;
   assign wb.wb_ack   = ack_q;
   assign wb.wb_dat_o = dat_q;

   always_comb begin
      bsel = '0;
      for (int i = 0; i < NIRQ; i++) bsel[i] = wb.wb_sel[i/8];
   end

   always_comb begin
      rdata = '0;
      case (wb.wb_adr)
         ADDR_MASK:  rdata[NIRQ-1:0] = mask_q;
         ADDR_EDGE:  rdata[NIRQ-1:0] = edge_q;
         ADDR_PEND:  rdata[NIRQ-1:0] = pend_q;
         ADDR_INSVC: rdata[NIRQ-1:0] = insvc_q;
         ADDR_VEC: begin
            if (wb_irq) begin
               rdata[VB]     = 1'b1;
               rdata[IW-1:0] = p_idx;
            end
         end
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      mask_d  = mask_q;
      edge_d  = edge_q;
      pend_d  = pend_q;
      insvc_d = insvc_q;
      dat_d   = dat_q;
      if (wr) begin
         case (wb.wb_adr)
            ADDR_MASK:  mask_d = (mask_q & ~bsel) | wn;
            ADDR_EDGE:  edge_d = (edge_q & ~bsel) | wn;
            ADDR_PEND:  pend_d = pend_q & ~wn;
            ADDR_EOI:   if (wb.wb_sel[0]) insvc_d = insvc_q & ~eoi_hot;
            ADDR_FORCE: pend_d = pend_q | (wn & edge_q);
            default:    ;
         endcase
      end
      if (rd) begin
         dat_d = rdata;
         if (wb.wb_adr == ADDR_VEC && wb_irq) begin
            insvc_d = insvc_q | p_hot;
            pend_d  = pend_q & ~(p_hot & edge_q);
         end
      end
      // A hardware edge wins over any clear in the same cycle; level lines track the input.
      pend_d = ((pend_d | rise) & edge_q) | (sy2_q & ~edge_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sy1_q   <= '0;
         sy2_q   <= '0;
         prv_q   <= '0;
         mask_q  <= '0;
         edge_q  <= '0;
         pend_q  <= '0;
         insvc_q <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         sy1_q   <= irq_i;
         sy2_q   <= sy1_q;
         prv_q   <= sy2_q;
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         pend_q  <= pend_d;
         insvc_q <= insvc_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
      end
   end
endmodule

// File: tb/tb_wb_vpic.sv
// Randomised and directed bench for wb_vpic against a behavioural model (NIRQ=8),
// plus directed checks on a NIRQ=32 instance.
module tb_wb_vpic;
   import wb_vpic_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  irq = 8'h00;
   logic [31:0] irq32 = 32'h0;
   logic        cyc = 1'b0, stb = 1'b0, bwe = 1'b0, tgt = 1'b0;
   logic [2:0]  badr = 3'd0;
   logic [31:0] bdat = 32'h0;
   logic [3:0]  bsel = 4'h0;
   logic        irq8, irq_32;
   logic [2:0]  no8;
   logic [4:0]  no32;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   wb_vpic_if #(.DW(32)) b8 ();
   wb_vpic_if #(.DW(32)) b32 ();

   assign b8.wb_cyc    = cyc & ~tgt;
   assign b8.wb_stb    = stb;
   assign b8.wb_we     = bwe;
   assign b8.wb_sel    = bsel;
   assign b8.wb_adr    = badr;
   assign b8.wb_dat_i  = bdat;
   assign b32.wb_cyc   = cyc & tgt;
   assign b32.wb_stb   = stb;
   assign b32.wb_we    = bwe;
   assign b32.wb_sel   = bsel;
   assign b32.wb_adr   = badr;
   assign b32.wb_dat_i = bdat;

   wb_vpic #(.NIRQ(8), .DW(32)) dut8 (
      .clk(clk), .rst(rst), .irq_i(irq), .wb(b8.slave), .wb_irq(irq8), .irq_no(no8));
   wb_vpic #(.NIRQ(32), .DW(32)) dut32 (
      .clk(clk), .rst(rst), .irq_i(irq32), .wb(b32.slave), .wb_irq(irq_32), .irq_no(no32));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the NIRQ=8 instance ----------------
   logic [7:0]  mmask = 0, medge = 0, mpend = 0, minsvc = 0;
   logic [7:0]  sm1 = 0, sm2 = 0, sm3 = 0;  // irq_i as sampled 1, 2, 3 edges ago
   logic        mack = 0, mrd = 0, fire;
   logic [31:0] mdat = 0;
   logic [7:0]  pd, rise, wn, eold;
   int          p;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 8;
   endfunction
   function automatic logic m_irq();
      int pp = lowest(mpend & mmask);
      return (pp < 8) && (pp < lowest(minsvc));
   endfunction
   function automatic int m_no();
      int pp = lowest(mpend & mmask);
      return (pp < 8) ? pp : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mmask = 0; medge = 0; mpend = 0; minsvc = 0;
         sm1 = 0; sm2 = 0; sm3 = 0; mack = 0; mrd = 0; mdat = 0;
      end else begin
         fire = b8.wb_cyc & b8.wb_stb & ~mack;
         mrd  = fire & ~b8.wb_we;
         eold = medge;
         pd   = mpend;
         rise = sm2 & ~sm3;
         wn   = b8.wb_dat_i[7:0] & {8{b8.wb_sel[0]}};
         if (fire && b8.wb_we) begin
            case (b8.wb_adr)
               3'd0: if (b8.wb_sel[0]) mmask = b8.wb_dat_i[7:0];
               3'd1: if (b8.wb_sel[0]) medge = b8.wb_dat_i[7:0];
               3'd2: pd = pd & ~wn;
               3'd5: if (b8.wb_sel[0]) minsvc[b8.wb_dat_i[2:0]] = 1'b0;
               3'd6: pd = pd | (wn & eold);
               default: ;
            endcase
         end
         if (mrd) begin
            case (b8.wb_adr)
               3'd0: mdat = {24'h0, mmask};
               3'd1: mdat = {24'h0, medge};
               3'd2: mdat = {24'h0, mpend};
               3'd3: mdat = {24'h0, minsvc};
               3'd4: begin
                  if (m_irq()) begin
                     p = lowest(mpend & mmask);
                     mdat = 32'h8000_0000 | p;
                     minsvc[p] = 1'b1;
                     if (eold[p]) pd[p] = 1'b0;
                  end else mdat = 0;
               end
               default: mdat = 0;
            endcase
         end
         mpend = ((pd | rise) & eold) | (sm2 & ~eold);
         mack  = fire;
         sm3 = sm2; sm2 = sm1; sm1 = irq;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("wb_irq", {31'b0, irq8}, {31'b0, m_irq()});
         chk("irq_no", {29'b0, no8}, 32'(m_no()));
         chk("wb_ack", {31'b0, b8.wb_ack}, {31'b0, mack});
         if (mrd) chk("rdata", b8.wb_dat_o, mdat);
      end
   end

   // ---------------- bus helpers ----------------
   task automatic bus(input logic t, input logic we, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
      int n;
      @(negedge clk);
      tgt = t; cyc = 1; stb = 1; bwe = we; badr = a; bdat = d; bsel = s; n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(t ? b32.wb_ack : b8.wb_ack) && n < 16);
      if (!(t ? b32.wb_ack : b8.wb_ack)) begin
         checks++; errors++;
         $display("FAIL bus_timeout: no ack after %0d cycles, expected ack", n);
      end
      r = t ? b32.wb_dat_o : b8.wb_dat_o;
      cyc = 0; stb = 0; bwe = 0;
   endtask
   task automatic wr(input logic t, input logic [2:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(t, 1'b1, a, d, 4'hF, dummy);
   endtask
   task automatic rd(input logic t, input logic [2:0] a, output logic [31:0] r);
      bus(t, 1'b0, a, 32'h0, 4'hF, r);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [2:0]  a;
      logic [31:0] d;
      irq = 8'hFF;
      #1 rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      // Reset state
      rd(0, ADDR_MASK, r);  chk("rst_mask", r, 0);
      rd(0, ADDR_EDGE, r);  chk("rst_edge", r, 0);
      rd(0, ADDR_INSVC, r); chk("rst_insvc", r, 0);
      rd(0, ADDR_VEC, r);   chk("rst_vec", r, 0);
      chk("rst_irq", {31'b0, irq8}, 0);
      irq = 8'h00;
      repeat (5) @(negedge clk);

      // Edge latch on line 2
      wr(0, ADDR_MASK, 32'h04);
      wr(0, ADDR_EDGE, 32'h04);
      @(negedge clk) irq = 8'h04;
      @(negedge clk) irq = 8'h00;
      @(negedge clk) chk("edge_lat2", {31'b0, irq8}, 0);
      @(negedge clk) chk("edge_lat3", {31'b0, irq8}, 1);
      chk("model_pend", {24'b0, mpend}, 32'h04);
      rd(0, ADDR_PEND, r);  chk("edge_pend", r, 32'h04);
      rd(0, ADDR_VEC, r);   chk("edge_vec", r, 32'h8000_0002);
      rd(0, ADDR_INSVC, r); chk("edge_insvc", r, 32'h04);
      rd(0, ADDR_PEND, r);  chk("edge_pend_clr", r, 0);
      chk("edge_irq_off", {31'b0, irq8}, 0);

      // Nesting: 2 in service, level 5 blocked, edge 1 preempts
      wr(0, ADDR_MASK, 32'h26);
      wr(0, ADDR_EDGE, 32'h06);
      irq = 8'h20;
      repeat (5) @(negedge clk);
      chk("nest_blocked", {31'b0, irq8}, 0);
      irq = 8'h22;
      repeat (5) @(negedge clk);
      chk("nest_irq", {31'b0, irq8}, 1);
      chk("nest_no", {29'b0, no8}, 1);
      rd(0, ADDR_VEC, r);   chk("nest_vec", r, 32'h8000_0001);
      wr(0, ADDR_EOI, 32'd1);
      chk("eoi1_irq", {31'b0, irq8}, 0);
      wr(0, ADDR_EOI, 32'd2);
      chk("eoi2_irq", {31'b0, irq8}, 1);
      chk("eoi2_no", {29'b0, no8}, 5);
      irq = 8'h00;
      repeat (5) @(negedge clk);

      // Level mode ignores W1C and follows the input
      wr(0, ADDR_MASK, 32'h00);
      irq = 8'h08;
      repeat (4) @(negedge clk);
      wr(0, ADDR_PEND, 32'h08);
      rd(0, ADDR_PEND, r);  chk("lvl_w1c", r, 32'h08);
      irq = 8'h00;
      repeat (4) @(negedge clk);
      rd(0, ADDR_PEND, r);  chk("lvl_drop", r, 0);

      // Hardware edge and W1C on bit 0 in the same cycle
      wr(0, ADDR_EDGE, 32'h07);
      wr(0, ADDR_MASK, 32'h01);
      @(negedge clk) irq = 8'h01;
      @(negedge clk);
      wr(0, ADDR_PEND, 32'h01);
      chk("model_collide", {24'b0, mpend}, 32'h01);
      rd(0, ADDR_PEND, r);  chk("collide_pend", r, 32'h01);
      wr(0, ADDR_MASK, 32'h00);
      rd(0, ADDR_VEC, r);   chk("vec_empty", r, 0);
      rd(0, ADDR_INSVC, r); chk("vec_empty_insvc", r, 0);
      irq = 8'h00;
      wr(0, ADDR_PEND, 32'h01);

      // Randomised traffic against the model
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            irq = 8'($urandom);
         end
         a = 3'($urandom);
         d = $urandom;
         if (a == ADDR_EOI) d = {29'b0, 3'($urandom)};
         if (a == ADDR_MASK && $urandom_range(0, 1) == 1) d = 32'hFF;
         bus(0, 1'($urandom), a, d, 4'($urandom) | 4'($urandom_range(0, 1)), r);
      end

      // NIRQ=32: forced edges are vectored in priority order
      wr(1, ADDR_EDGE, 32'hFFFF_FFFF);
      wr(1, ADDR_MASK, 32'hFFFF_FFFF);
      wr(1, ADDR_FORCE, 32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         rd(1, ADDR_VEC, r);
         chk("vec32", r, 32'h8000_0000 | i);
         wr(1, ADDR_EOI, i);
      end
      rd(1, ADDR_PEND, r);  chk("pend32_empty", r, 0);
      wr(1, ADDR_MASK, 32'hAAAA_AAAA);
      bus(1, 1'b1, ADDR_MASK, 32'hFF, 4'b0001, r);
      rd(1, ADDR_MASK, r);  chk("sel_byte0", r, 32'hAAAA_AAFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
